// File: rtl/hms_counter.sv
// Time-of-day counter: cascaded seconds/minutes/hours fields advanced by a tick,
// with up/down counting, clamped synchronous load, set-mode steps and registered wrap pulses.
module hms_counter #(
  parameter int SEC_MOD = 60,
  parameter int MIN_MOD = 60,
  parameter int HR_MOD  = 24,
  parameter int SW      = 6,
  parameter int HW      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_tick,
  input  logic          i_dir,
  input  logic          i_load,
  input  logic [SW-1:0] i_sec_ld,
  input  logic [SW-1:0] i_min_ld,
  input  logic [HW-1:0] i_hr_ld,
  input  logic          i_inc_sec,
  input  logic          i_inc_min,
  input  logic          i_inc_hr,
  output logic [SW-1:0] o_sec,
  output logic [SW-1:0] o_min,
  output logic [HW-1:0] o_hr,
  output logic          o_sec_carry,
  output logic          o_min_carry,
  output logic          o_day_carry
);

  localparam logic [SW-1:0] SEC_MAX = SW'(SEC_MOD - 1);
  localparam logic [SW-1:0] MIN_MAX = SW'(MIN_MOD - 1);
  localparam logic [HW-1:0] HR_MAX  = HW'(HR_MOD - 1);

  logic [SW-1:0] sec_q, sec_d, min_q, min_d;
  logic [HW-1:0] hr_q, hr_d;
  logic          sec_carry_q, sec_carry_d;
  logic          min_carry_q, min_carry_d;
  logic          day_carry_q, day_carry_d;
  logic          any_inc;

  function automatic logic [SW-1:0] up_sw(input logic [SW-1:0] v, input logic [SW-1:0] vmax);
    return (v >= vmax) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [SW-1:0] down_sw(input logic [SW-1:0] v, input logic [SW-1:0] vmax);
    return (v == '0) ? vmax : v - 1'b1;
  endfunction

  function automatic logic [HW-1:0] up_hw(input logic [HW-1:0] v, input logic [HW-1:0] vmax);
    return (v >= vmax) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [HW-1:0] down_hw(input logic [HW-1:0] v, input logic [HW-1:0] vmax);
    return (v == '0) ? vmax : v - 1'b1;
  endfunction

  assign any_inc = i_inc_sec | i_inc_min | i_inc_hr;

  // Load beats set steps beats tick; the whole cascade settles within one cycle.
  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    sec_carry_d = 1'b0;
    min_carry_d = 1'b0;
    day_carry_d = 1'b0;
    if (i_load) begin
      sec_d = (i_sec_ld > SEC_MAX) ? '0 : i_sec_ld;
      min_d = (i_min_ld > MIN_MAX) ? '0 : i_min_ld;
      hr_d  = (i_hr_ld  > HR_MAX)  ? '0 : i_hr_ld;
    end else if (any_inc) begin
      if (i_inc_sec) sec_d = up_sw(sec_q, SEC_MAX);
      if (i_inc_min) min_d = up_sw(min_q, MIN_MAX);
      if (i_inc_hr)  hr_d  = up_hw(hr_q, HR_MAX);
    end else if (i_tick) begin
      if (!i_dir) begin
        sec_carry_d = (sec_q >= SEC_MAX);
        sec_d       = up_sw(sec_q, SEC_MAX);
        if (sec_carry_d) begin
          min_carry_d = (min_q >= MIN_MAX);
          min_d       = up_sw(min_q, MIN_MAX);
        end
        if (min_carry_d) begin
          day_carry_d = (hr_q >= HR_MAX);
          hr_d        = up_hw(hr_q, HR_MAX);
        end
      end else begin
        sec_carry_d = (sec_q == '0);
        sec_d       = down_sw(sec_q, SEC_MAX);
        if (sec_carry_d) begin
          min_carry_d = (min_q == '0);
          min_d       = down_sw(min_q, MIN_MAX);
        end
        if (min_carry_d) begin
          day_carry_d = (hr_q == '0);
          hr_d        = down_hw(hr_q, HR_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= '0;
      min_q       <= '0;
      hr_q        <= '0;
      sec_carry_q <= 1'b0;
      min_carry_q <= 1'b0;
      day_carry_q <= 1'b0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      sec_carry_q <= sec_carry_d;
      min_carry_q <= min_carry_d;
      day_carry_q <= day_carry_d;
    end
  end

  assign o_sec       = sec_q;
  assign o_min       = min_q;
  assign o_hr        = hr_q;
  assign o_sec_carry = sec_carry_q;
  assign o_min_carry = min_carry_q;
  assign o_day_carry = day_carry_q;

endmodule

// File: tb/tb_hms_counter.sv
// Scoreboard bench for hms_counter: a default 24h instance checked against a
// total-seconds model, plus a small-modulus instance for back-to-back ticking.
module tb_hms_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, dir, load, inc_sec, inc_min, inc_hr;
  logic [5:0] sec_ld, min_ld;
  logic [4:0] hr_ld;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic       sec_carry, min_carry, day_carry;

  logic       s_tick;
  logic [5:0] s_sec, s_min;
  logic [3:0] s_hr;
  logic       s_sec_carry, s_min_carry, s_day_carry;

  int n_checks = 0;
  int n_bad    = 0;

  typedef struct {
    string tag;
    int    sec, min, hr;
    bit    sc, mc, dc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   ms = 0, mm = 0, mh = 0;

  always #5 clk = ~clk;

  hms_counter dut (
    .clk(clk), .rst_n(rst_n), .i_tick(tick), .i_dir(dir), .i_load(load),
    .i_sec_ld(sec_ld), .i_min_ld(min_ld), .i_hr_ld(hr_ld),
    .i_inc_sec(inc_sec), .i_inc_min(inc_min), .i_inc_hr(inc_hr),
    .o_sec(sec), .o_min(min), .o_hr(hr),
    .o_sec_carry(sec_carry), .o_min_carry(min_carry), .o_day_carry(day_carry)
  );

  hms_counter #(.SEC_MOD(10), .MIN_MOD(6), .HR_MOD(12), .HW(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .i_tick(s_tick), .i_dir(1'b0), .i_load(1'b0),
    .i_sec_ld(6'd0), .i_min_ld(6'd0), .i_hr_ld(4'd0),
    .i_inc_sec(1'b0), .i_inc_min(1'b0), .i_inc_hr(1'b0),
    .o_sec(s_sec), .o_min(s_min), .o_hr(s_hr),
    .o_sec_carry(s_sec_carry), .o_min_carry(s_min_carry), .o_day_carry(s_day_carry)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the model's prediction.
  task automatic applyStimulus(input string tag, input bit ld, input int sl, input int ml,
                               input int hl, input bit is, input bit im, input bit ih,
                               input bit tk, input bit dr);
    exp_t e;
    int   t;
    @(negedge clk);
    load = ld; sec_ld = 6'(sl); min_ld = 6'(ml); hr_ld = 5'(hl);
    inc_sec = is; inc_min = im; inc_hr = ih; tick = tk; dir = dr;
    e.tag = tag; e.sc = 0; e.mc = 0; e.dc = 0;
    if (ld) begin
      ms = (sl >= 60) ? 0 : sl;
      mm = (ml >= 60) ? 0 : ml;
      mh = (hl >= 24) ? 0 : hl;
    end else if (is || im || ih) begin
      if (is) ms = (ms + 1) % 60;
      if (im) mm = (mm + 1) % 60;
      if (ih) mh = (mh + 1) % 24;
    end else if (tk) begin
      t = mh * 3600 + mm * 60 + ms;
      if (!dr) begin
        e.sc = (ms == 59); e.mc = e.sc && (mm == 59); e.dc = e.mc && (mh == 23);
        t = (t + 1) % 86400;
      end else begin
        e.sc = (ms == 0); e.mc = e.sc && (mm == 0); e.dc = e.mc && (mh == 0);
        t = (t + 86399) % 86400;
      end
      ms = t % 60; mm = (t / 60) % 60; mh = t / 3600;
    end
    e.sec = ms; e.min = mm; e.hr = mh;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput({mon_e.tag, ".sec"}, 32'(sec), 32'(mon_e.sec));
      checkOutput({mon_e.tag, ".min"}, 32'(min), 32'(mon_e.min));
      checkOutput({mon_e.tag, ".hr"}, 32'(hr), 32'(mon_e.hr));
      checkOutput({mon_e.tag, ".sc"}, 32'(sec_carry), 32'(mon_e.sc));
      checkOutput({mon_e.tag, ".mc"}, 32'(min_carry), 32'(mon_e.mc));
      checkOutput({mon_e.tag, ".dc"}, 32'(day_carry), 32'(mon_e.dc));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sc_cnt, mc_cnt, dc_cnt, r;
    rst_n = 0; s_tick = 0;
    tick = 0; dir = 0; load = 0; inc_sec = 0; inc_min = 0; inc_hr = 0;
    sec_ld = '0; min_ld = '0; hr_ld = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.sec", 32'(sec), 0);
    checkOutput("rst.hr", 32'(hr), 0);
    checkOutput("rst.carries", 32'({sec_carry, min_carry, day_carry}), 0);
    @(negedge clk) rst_n = 1;

    applyStimulus("ld30", 1, 30, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus("run", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    tick = 0;
    #2 rst_n = 0;
    #1;
    checkOutput("midrst.sec", 32'(sec), 0);
    checkOutput("midrst.all", 32'({min, hr, sec_carry, min_carry, day_carry}), 0);
    ms = 0; mm = 0; mh = 0;
    @(negedge clk) rst_n = 1;
    idle("postrst.hold");
    applyStimulus("postrst.tick", 0, 0, 0, 0, 0, 0, 0, 1, 0);

    applyStimulus("ld235959", 1, 59, 59, 23, 0, 0, 0, 0, 0);
    applyStimulus("upwrap", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("upwrap.after");

    applyStimulus("ld0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus("down1", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus("down2", 0, 0, 0, 0, 0, 0, 0, 1, 1);

    applyStimulus("clamp", 1, 61, 12, 30, 0, 1, 0, 1, 0);
    idle("clamp.after");
    applyStimulus("clamp.edge", 1, 60, 59, 24, 0, 0, 0, 0, 0);

    applyStimulus("ld105959", 1, 59, 59, 10, 0, 0, 0, 0, 0);
    applyStimulus("incms", 0, 0, 0, 0, 1, 1, 0, 1, 0);
    applyStimulus("ld23h", 1, 0, 0, 23, 0, 0, 0, 0, 0);
    applyStimulus("inchr", 0, 0, 0, 0, 0, 0, 1, 1, 1);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 9)
        applyStimulus("rnd.ld", 1, $urandom_range(0, 63), $urandom_range(0, 63),
                      $urandom_range(0, 31), 0, 0, 0, 1, 0);
      else if (r == 8)
        applyStimulus("rnd.inc", 0, 0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        applyStimulus("rnd.tick", 0, 0, 0, 0, 0, 0, 0, r < 7, 1'($urandom_range(0, 1)));
    end
    idle("final.hold");
    @(negedge clk);
    checkOutput("queue.empty", 32'(exp_q.size()), 0);

    sc_cnt = 0; mc_cnt = 0; dc_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk) s_tick = 1;
      @(posedge clk);
      #1;
      sc_cnt += int'(s_sec_carry);
      mc_cnt += int'(s_min_carry);
      dc_cnt += int'(s_day_carry);
    end
    @(negedge clk) s_tick = 0;
    checkOutput("small.sc_cnt", 32'(sc_cnt), 6);
    checkOutput("small.mc_cnt", 32'(mc_cnt), 1);
    checkOutput("small.dc_cnt", 32'(dc_cnt), 0);
    checkOutput("small.hms", 32'({s_hr, s_min, s_sec}), 32'({4'd1, 6'd0, 6'd0}));
    @(posedge clk);
    #1;
    checkOutput("small.carry_drop", 32'({s_sec_carry, s_min_carry}), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hms_counter.md
# hms_counter

Parametrised time-of-day counter: three cascaded modulo fields (seconds, minutes, hours) advanced by a one-cycle tick. It supports up/down counting, synchronous load and per-field set increments. Registered carry pulses are provided for downstream alarm and date logic. It sits between the 1 Hz tick generator and the 7-segment display/alarm blocks of the digital-clock design. It is the generalised successor of the single mod-60 counter.

## Interface

Parameters:
- SEC_MOD, 60, seconds modulus (field counts 0..SEC_MOD-1)
- MIN_MOD, 60, minutes modulus
- HR_MOD, 24, hours modulus
- SW, 6, seconds/minutes field width; must satisfy 2^SW >= max(SEC_MOD, MIN_MOD)
- HW, 5, hours field width; must satisfy 2^HW >= HR_MOD

Ports:
- clk, in, 1, the single clock
- rst_n, in, 1, reset, asynchronous, active-low
- i_tick, in, 1, advance one second (one-cycle pulse)
- i_dir, in, 1, count direction: 0 = up, 1 = down
- i_load, in, 1, synchronous load of all three fields
- i_sec_ld, in, SW, seconds load value
- i_min_ld, in, SW, minutes load value
- i_hr_ld, in, HW, hours load value
- i_inc_sec, in, 1, set-mode single step of the seconds field
- i_inc_min, in, 1, set-mode single step of the minutes field
- i_inc_hr, in, 1, set-mode single step of the hours field
- o_sec, out, SW, seconds value
- o_min, out, SW, minutes value
- o_hr, out, HW, hours value
- o_sec_carry, out, 1, seconds wrapped (one-cycle pulse)
- o_min_carry, out, 1, minutes wrapped (one-cycle pulse)
- o_day_carry, out, 1, hours wrapped (one-cycle pulse)

## Operation

- Reset (rst_n low, asynchronous): all fields = 0; all carries = 0. Reset wins over every input at any time, including mid-load and mid-cascade.
- Priority per cycle: i_load > any i_inc_* > i_tick. A lower-priority input asserted together with a higher one is dropped. It is not queued.
- Load:
  - Each field takes its load value.
  - A value >= its modulus is loaded as 0. Each field is checked independently.
  - Carries are 0 in a load cycle.
- Set increments:
  - Each asserted i_inc_* steps its own field by +1 mod its modulus. i_dir is ignored.
  - There is no cascade into the next field.
  - Carries are 0.
  - Several i_inc_* asserted together each act on their own field.
- Tick, up (i_dir = 0):
  - Seconds +1.
  - At SEC_MOD-1 (or any value >= SEC_MOD-1), seconds goes to 0, o_sec_carry is asserted, and minutes advances by the same rule.
  - A minutes wrap asserts o_min_carry and advances hours.
  - An hours wrap (HR_MOD-1 -> 0) asserts o_day_carry.
  - The full cascade resolves in the same cycle.
- Tick, down (i_dir = 1):
  - Seconds -1.
  - At 0, seconds goes to SEC_MOD-1, o_sec_carry is asserted (as a borrow), and minutes decrements.
  - Minutes and hours follow the same rule. An hours borrow 0 -> HR_MOD-1 asserts o_day_carry.
- Width rule: all compare and next-value logic uses the field width. Intermediate values never exceed modulus-1, so there is no overflow.
- Without i_tick, i_load or i_inc_*, all fields hold and carries are 0.

## Timing

- All outputs are registered, with no combinational input-to-output path.
- Latency: an input sampled at rising edge N produces updated fields at edge N, visible from N until N+1.
- Carries assert in the same cycle as the field wrap and last exactly one cycle, even for back-to-back ticks.
- A tick every cycle is legal: each cycle advances one step, and carries pulse on every wrap.
- i_dir may change on any cycle. It is sampled only with i_tick.
- Reset release: the first edge with rst_n high may act on inputs.

## Test plan

- Reset mid-count: run to 00:00:37, assert rst_n low between edges -> all outputs 0 immediately, carries 0, fields remain 0 until the next tick.
- Full up cascade: load 23:59:59, tick once -> 00:00:00, with o_sec_carry, o_min_carry and o_day_carry all high for exactly one cycle, then all low.
- Down borrow: load 00:00:00, i_dir = 1, tick -> 23:59:59, all three carries high for one cycle; second tick -> 23:59:58, carries 0.
- Load clamp and priority: i_load with sec = 61, min = 12, hr = 30, together with i_tick and i_inc_min -> 00:12:00 (hours 0, minutes 12, seconds 0), tick and increment ignored, no carries.
- Set increments: from 10:59:59, assert i_inc_min and i_inc_sec together with i_tick -> 10:00:00 (minutes 59 -> 0 and seconds 59 -> 0 with no cascade, hours stay 10), tick dropped, carries 0.
- Back-to-back ticks with parameter override SEC_MOD = 10, MIN_MOD = 6, HR_MOD = 12, HW = 4: 60 consecutive ticks from 0 -> o_sec_carry pulses 6 times and o_min_carry once, ending at hours 1, minutes 0, seconds 0.
